// File: rtl/mem_bank_cfg_loader.sv
// Memory-bank configuration loader: assembles a byte stream into BL_W-bit bitline words
// and strobes one wordline per row. Optional CRC-8 trailer check when CFG_CRC_EN is defined.
module mem_bank_cfg_loader #(
    parameter int BL_W     = 40,
    parameter int WL_W     = 4,
    parameter int WL_PULSE = 2
) (
    input  logic            prog_clk,
    input  logic            prog_rst_n,
    input  logic            start,
    input  logic [7:0]      cfg_data,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    output logic [BL_W-1:0] bl_out,
    output logic [WL_W-1:0] wl_out,
    output logic            busy,
    output logic            done,
    output logic            cfg_err
);

    localparam int BEATS   = BL_W / 8;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W   = (WL_W > 1) ? $clog2(WL_W) : 1;
    localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(WL_W - 1);
    localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
`ifdef CFG_CRC_EN
        S_DONE   = 3'd5,
        S_CHECK  = 3'd6
`else
        S_DONE   = 3'd5
`endif
    } state_t;

    state_t             state;
    logic [BEAT_W-1:0]  beat;
    logic [ROW_W-1:0]   row;
    logic [PULSE_W-1:0] pulse;
    logic               accept;

    // Handshake: a byte transfers on a rising edge where cfg_valid && cfg_ready.
    // cfg_ready is a registered state decode and never looks at cfg_valid.
    assign accept = cfg_valid && cfg_ready;

`ifdef CFG_CRC_EN
    logic [7:0] crc;
    logic       cfg_err_q;

    // CRC-8, poly 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] d);
        logic [7:0] c;
        c = crc_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= S_IDLE;
            beat      <= '0;
            row       <= '0;
            pulse     <= '0;
            bl_out    <= '0;
            wl_out    <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CFG_CRC_EN
            crc       <= 8'h00;
            cfg_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        row       <= '0;
                        beat      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cfg_ready <= 1'b1;
`ifdef CFG_CRC_EN
                        crc       <= 8'h00;
                        cfg_err_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        // First byte of a row lands in the LSBs.
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat == BEAT_W'(k)) begin
                                bl_out[8*k +: 8] <= cfg_data;
                            end
                        end
`ifdef CFG_CRC_EN
                        crc <= crc8_next(crc, cfg_data);
`endif
                        if (beat == LAST_BEAT) begin
                            cfg_ready <= 1'b0;
                            state     <= S_SETUP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    wl_out <= WL_W'(1) << row;
                    pulse  <= '0;
                    state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (pulse == LAST_PULSE) begin
                        wl_out <= '0;
                        state  <= S_HOLD;
                    end else begin
                        pulse <= pulse + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (row != LAST_ROW) begin
                        row       <= row + 1'b1;
                        beat      <= '0;
                        cfg_ready <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
`ifdef CFG_CRC_EN
                        cfg_ready <= 1'b1;
                        state     <= S_CHECK;
`else
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
`endif
                    end
                end
`ifdef CFG_CRC_EN
                S_CHECK: begin
                    // The trailing byte is the expected CRC of all data bytes.
                    if (accept) begin
                        cfg_ready <= 1'b0;
                        cfg_err_q <= (cfg_data != crc);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    wl_out    <= '0;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_cfg_loader.sv
// Bench for mem_bank_cfg_loader: table of full loads checked through a row-word scoreboard,
// plus reset-state and reset-during-strobe sequences. Define CFG_CRC_EN to exercise the CRC trailer.
module tb_mem_bank_cfg_loader;

    localparam int BL_W     = 40;
    localparam int WL_W     = 4;
    localparam int WL_PULSE = 2;
    localparam int BEATS    = BL_W / 8;
    localparam int NBYTES   = BEATS * WL_W;
`ifdef CFG_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    logic            prog_clk   = 1'b0;
    logic            prog_rst_n = 1'b0;
    logic            start      = 1'b0;
    logic [7:0]      cfg_data   = 8'h00;
    logic            cfg_valid  = 1'b0;
    logic            cfg_ready;
    logic [BL_W-1:0] bl_out;
    logic [WL_W-1:0] wl_out;
    logic            busy;
    logic            done;
    logic            cfg_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [BL_W-1:0] exp_q[$];
    logic [BL_W-1:0] last_word;
    logic [7:0]      bytes[NBYTES];

    typedef struct {
        logic [7:0] base;
        bit         rnd;
        int         gap_at;
        int         gap_len;
        bit         start_mid;
        bit         bad_crc;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    mem_bank_cfg_loader #(.BL_W(BL_W), .WL_W(WL_W), .WL_PULSE(WL_PULSE)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .bl_out     (bl_out),
        .wl_out     (wl_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // clock / reset
    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bitwise reference CRC-8 (poly 0x07, init 0, MSB first).
    function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    // driver tasks; called at a negedge, return at the negedge after the byte transfers
    task automatic send_byte(input logic [7:0] b);
        int n;
        cfg_data  = b;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        if (!cfg_ready) check("ready_timeout", {63'd0, cfg_ready}, 64'd1);
        @(negedge prog_clk);
    endtask

    task automatic drive_bytes(input vec_t v);
        logic [BL_W-1:0] w;
        logic [7:0]      sb;
        logic [7:0]      crc;
        w   = '0;
        crc = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (v.gap_len > 0 && i == v.gap_at) begin
                cfg_valid = 1'b0;
                repeat (v.gap_len) @(negedge prog_clk);
            end
            sb  = bytes[i];
            crc = ref_crc(crc, bytes[i]);
`ifdef CFG_CRC_EN
            if (v.bad_crc && i == 7) sb = sb ^ 8'h5A;
`endif
            w[8*(i % BEATS) +: 8] = sb;
            if (i % BEATS == BEATS - 1) begin
                exp_q.push_back(w);
                last_word = w;
            end
            send_byte(sb);
        end
`ifdef CFG_CRC_EN
        send_byte(crc);
`endif
        cfg_valid = 1'b0;
    endtask

    // monitor: pops one expected word per wordline strobe
    task automatic monitor_rows(input vec_t v, input int t0);
        int              row;
        int              len;
        int              n;
        logic [WL_W-1:0] prev;
        logic [BL_W-1:0] w;
        bit              clr_start;
        row = 0; len = 0; n = 0; prev = '0; w = '0; clr_start = 0;
        while (!done && n < 500) begin
            @(negedge prog_clk);
            n++;
            if (clr_start) begin
                start = 1'b0;
                clr_start = 0;
            end
            if (wl_out != '0) begin
                if (prev == '0) begin
                    if (exp_q.size() == 0) begin
                        check("strobe_before_row_loaded", 64'(wl_out), 64'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check("row_bl", 64'(bl_out), 64'(w));
                    end
                    check("row_wl", 64'(wl_out), 64'(1) << row);
                    len = 0;
                    if (v.start_mid && row == 1) begin
                        start = 1'b1;
                        clr_start = 1;
                    end
                end
                len++;
            end else if (prev != '0) begin
                check("wl_pulse_len", 64'(len), 64'(WL_PULSE));
                check("bl_hold", 64'(bl_out), 64'(w));
                row++;
            end
            prev = wl_out;
        end
        check("rows_strobed", 64'(row), 64'(WL_W));
        check("done_latency", 64'(cyc - t0), 64'(v.exp_lat));
    endtask

    task automatic run_load(input vec_t v);
        int t0;
        for (int j = 0; j < NBYTES; j++) begin
            bytes[j] = v.rnd ? 8'($urandom_range(0, 255)) : 8'(v.base + 8'(j));
        end
        exp_q.delete();
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        t0 = cyc;
        check("start_clears_done", {63'd0, done}, 64'd0);
        check("start_sets_busy", {63'd0, busy}, 64'd1);
        check("start_sets_ready", {63'd0, cfg_ready}, 64'd1);
        fork
            drive_bytes(v);
            monitor_rows(v, t0);
        join
        check("end_done", {63'd0, done}, 64'd1);
        check("end_busy", {63'd0, busy}, 64'd0);
        check("end_ready", {63'd0, cfg_ready}, 64'd0);
        check("end_bl_last_row", 64'(bl_out), 64'(last_word));
`ifdef CFG_CRC_EN
        check("cfg_err", {63'd0, cfg_err}, {63'd0, v.bad_crc});
`else
        check("cfg_err", {63'd0, cfg_err}, 64'd0);
`endif
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_mid_strobe();
        int n;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        cfg_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            if (wl_out == 4'b0100) break;
            cfg_data = 8'(8'h30 + n);
            @(negedge prog_clk);
        end
        check("rst_reached_row2", 64'(wl_out), 64'h4);
        #2 prog_rst_n = 1'b0;
        #1;
        check("async_rst_wl", 64'(wl_out), 64'd0);
        check("async_rst_bl", 64'(bl_out), 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        check("post_rst_idle_ready", {63'd0, cfg_ready}, 64'd0);
        check("post_rst_idle_busy", {63'd0, busy}, 64'd0);
        check("post_rst_idle_done", {63'd0, done}, 64'd0);
        check("post_rst_idle_wl", 64'(wl_out), 64'd0);
    endtask

    initial begin
        vecs[0] = '{base: 8'h00, rnd: 0, gap_at: 0, gap_len: 0, start_mid: 0, bad_crc: 0, exp_lat: 36 + CRC_EXTRA};
        vecs[1] = '{base: 8'h40, rnd: 0, gap_at: 7, gap_len: 3, start_mid: 0, bad_crc: 0, exp_lat: 39 + CRC_EXTRA};
        vecs[2] = '{base: 8'hA0, rnd: 0, gap_at: 0, gap_len: 0, start_mid: 1, bad_crc: 0, exp_lat: 36 + CRC_EXTRA};
        vecs[3] = '{base: 8'h00, rnd: 1, gap_at: 2, gap_len: 1, start_mid: 0, bad_crc: 1, exp_lat: 37 + CRC_EXTRA};
        vecs[4] = '{base: 8'hF0, rnd: 0, gap_at: 0, gap_len: 0, start_mid: 0, bad_crc: 0, exp_lat: 36 + CRC_EXTRA};

        repeat (3) @(negedge prog_clk);
        check("rst_bl", 64'(bl_out), 64'd0);
        check("rst_wl", 64'(wl_out), 64'd0);
        check("rst_ready", {63'd0, cfg_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, cfg_err}, 64'd0);
        prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        check("idle_ready", {63'd0, cfg_ready}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            if (i == 4) reset_mid_strobe();
            run_load(vecs[i]);
        end

        repeat (5) @(negedge prog_clk);
        check("done_sticky", {63'd0, done}, 64'd1);
        check("done_busy_low", {63'd0, busy}, 64'd0);
        check("done_bl_held", 64'(bl_out), 64'(last_word));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
